adder_bist_ctrl: RTL



---
 rtl/adder_bist_pkg.sv | 40 ++++
 rtl/adder_bist_lfsr.sv | 30 +++
 rtl/adder_bist_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/adder_bist_pkg.sv
// Shared constants for the adder-bank BIST controller: FSM encoding, LFSR polynomial,
// operand-B scrambling and the corner-vector tables used when ADDER_BIST_CORNER_EN is defined.
package adder_bist_pkg;

    localparam int NUM_ADDERS  = 5;
    localparam int NUM_CORNERS = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DRIVE  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Galois taps for x^32+x^22+x^2+x+1, right-shifting form
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0] B_XOR     = 32'h5A5A_5A5A;

    // Entry 0 is the rightmost element of each packed table
    localparam logic [NUM_CORNERS-1:0][31:0] CORNER_A = {
        32'h0000_FFFF, 32'h0000_0001, 32'hAAAA_AAAA, 32'h8000_0000,
        32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000
    };
    localparam logic [NUM_CORNERS-1:0][31:0] CORNER_B = {
        32'h0000_0001, 32'hFFFF_FFFE, 32'h5555_5555, 32'h8000_0000,
        32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000
    };

    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_MASK : 32'h0);
    endfunction

    function automatic logic [31:0] derive_b(input logic [31:0] cur);
        return {cur[15:0], cur[31:16]} ^ B_XOR;
    endfunction

    function automatic logic [31:0] safe_seed(input logic [31:0] seed);
        return (seed == 32'h0) ? 32'h1 : seed;
    endfunction

endpackage

// File: rtl/adder_bist_lfsr.sv
// 32-bit Galois LFSR operand generator; a zero seed is replaced by 1 so the
// all-zero lock-up state can never be entered.
module adder_bist_lfsr
    import adder_bist_pkg::*;
#(
    parameter logic [31:0] RESET_SEED = 32'h1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic [31:0] i_seed,
    input  logic        i_step,
    output logic [31:0] o_state
);

    logic [31:0] state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= safe_seed(RESET_SEED);
        end else if (i_load) begin
            state <= safe_seed(i_seed);
        end else if (i_step) begin
            state <= lfsr_next(state);
        end
    end

    assign o_state = state;

endmodule

// File: rtl/adder_bist_ctrl.sv
// BIST controller for the 32-bit adder bank: drives operands, checks all sums against a+b.
// Define ADDER_BIST_CORNER_EN to prefix each run with the fixed corner-vector table.
module adder_bist_ctrl
    import adder_bist_pkg::*;
#(
    parameter int          NUM_VECTORS   = 1024,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [31:0] SEED          = 32'hACE1_2025
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    output logic [31:0] o_a,
    output logic [31:0] o_b,
    input  logic [31:0] i_sum_cra,
    input  logic [31:0] i_sum_cla,
    input  logic [31:0] i_sum_csa,
    input  logic [31:0] i_sum_cska,
    input  logic [31:0] i_sum_ksa,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic [4:0]  o_err_mask,
    output logic [15:0] o_err_count,
    output logic [15:0] o_vec_count
);

    localparam logic [31:0] SEED_EFF    = safe_seed(SEED);
    localparam logic [15:0] LAST_VECTOR = 16'(NUM_VECTORS);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [2:0]  AFTER_DRIVE = (SETTLE_CYCLES > 0) ? ST_SETTLE : ST_CHECK;

    logic [2:0]            state;
    logic [31:0]           a;
    logic [31:0]           b;
    logic [15:0]           settle_cnt;
    logic [NUM_ADDERS-1:0] err_mask;
    logic [15:0]           err_count;
    logic [15:0]           vec_count;

    logic [31:0]           lfsr_state;
    logic                  lfsr_load;
    logic                  lfsr_step;
    logic                  use_corner;
    logic [31:0]           drive_a;
    logic [31:0]           drive_b;
    logic [31:0]           golden;
    logic [NUM_ADDERS-1:0] mismatch;
    logic [15:0]           vec_next;
    logic                  start_ok;

    assign start_ok  = i_start && ((state == ST_IDLE) || (state == ST_DONE));
    assign lfsr_load = start_ok;
    assign lfsr_step = (state == ST_DRIVE) && !use_corner;

    adder_bist_lfsr #(
        .RESET_SEED (SEED_EFF)
    ) u_lfsr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (lfsr_load),
        .i_seed  (SEED_EFF),
        .i_step  (lfsr_step),
        .o_state (lfsr_state)
    );

`ifdef ADDER_BIST_CORNER_EN
    // Corner vectors take the first slots of the run and leave the LFSR untouched
    assign use_corner = (vec_count < 16'(NUM_CORNERS));

    always_comb begin
        drive_a = lfsr_state;
        drive_b = derive_b(lfsr_state);
        if (use_corner) begin
            drive_a = CORNER_A[vec_count[2:0]];
            drive_b = CORNER_B[vec_count[2:0]];
        end
    end
`else
    assign use_corner = 1'b0;
    assign drive_a    = lfsr_state;
    assign drive_b    = derive_b(lfsr_state);
`endif

    always_comb begin
        golden   = a + b;
        mismatch = {i_sum_ksa  != golden,
                    i_sum_cska != golden,
                    i_sum_csa  != golden,
                    i_sum_cla  != golden,
                    i_sum_cra  != golden};
        vec_next = vec_count + 16'd1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            a          <= 32'h0;
            b          <= 32'h0;
            settle_cnt <= 16'h0;
            err_mask   <= '0;
            err_count  <= 16'h0;
            vec_count  <= 16'h0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        err_mask  <= '0;
                        err_count <= 16'h0;
                        vec_count <= 16'h0;
                        state     <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    a          <= drive_a;
                    b          <= drive_b;
                    settle_cnt <= 16'h0;
                    state      <= AFTER_DRIVE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 16'd1;
                    end
                end
                ST_CHECK: begin
                    err_mask <= err_mask | mismatch;
                    // Count is per vector, not per failing adder, and sticks at all-ones
                    if ((|mismatch) && (err_count != 16'hFFFF)) begin
                        err_count <= err_count + 16'd1;
                    end
                    vec_count <= vec_next;
                    state     <= (vec_next == LAST_VECTOR) ? ST_DONE : ST_DRIVE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_a         = a;
    assign o_b         = b;
    assign o_busy      = (state == ST_DRIVE) || (state == ST_SETTLE) || (state == ST_CHECK);
    assign o_done      = (state == ST_DONE);
    assign o_pass      = (state == ST_DONE) && (err_count == 16'h0);
    assign o_err_mask  = err_mask;
    assign o_err_count = err_count;
    assign o_vec_count = vec_count;

endmodule
